// File: rtl/fetch_pc_pkg.sv
// Shared constants and bundles for the instruction-fetch stage.
// Reset values, next-PC select encodings and the IF/ID register layout.
package fetch_pc_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_npc_calc.sv
// Next-PC target generation and redirect priority (jr > j > branch > seq).
// Purely combinational; controls only count while IF/ID holds an instruction.
module npc_calc
    import fetch_pc_pkg::*;
(
    input  logic [31:0] pc_if,
    input  logic [31:0] pc_id,
    input  logic        id_valid,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] j_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] npc
);

    logic [1:0]  sel;
    logic [31:0] pc_id_plus4;

    assign pc_id_plus4 = pc_id + 32'd4;

    // Overlapping controls are possible, so the order here is the priority.
    always_comb begin
        sel = NPC_SEQ;
        priority case (1'b1)
            id_valid & jr:       sel = NPC_JR;
            id_valid & jump:     sel = NPC_J;
            id_valid & br_taken: sel = NPC_BR;
            default:             sel = NPC_SEQ;
        endcase
    end

    always_comb begin
        npc = pc_if + 32'd4;
        case (sel)
            NPC_JR:  npc = jr_target;
            NPC_J:   npc = {pc_id_plus4[31:28], j_index, 2'b00};
            NPC_BR:  npc = pc_id_plus4 + br_offset;
            default: npc = pc_if + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_pc.sv
// Fetch stage: PC register, IF/ID register, stall gating, jr misalign flag.
// Redirects resolved in ID take effect after one delay-slot fetch.
module fetch_pc
    import fetch_pc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_if,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] j_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_if,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc8_id,
    output logic        id_valid,
    output logic        jr_misalign
);

    logic [31:0] pc_q;
    logic [31:0] npc;
    if_id_t      ifid_q;
    logic        mis_q;

    npc_calc u_npc (
        .pc_if     (pc_q),
        .pc_id     (ifid_q.pc),
        .id_valid  (ifid_q.valid),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .jump      (jump),
        .j_index   (j_index),
        .jr        (jr),
        .jr_target (jr_target),
        .npc       (npc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= PC_RESET;
            ifid_q.instr <= NOP_WORD;
            ifid_q.pc    <= PC_RESET;
            ifid_q.valid <= 1'b0;
            mis_q        <= 1'b0;
        end else if (!stall) begin
            pc_q         <= npc;
            ifid_q.instr <= instr_if;
            ifid_q.pc    <= pc_q;
            ifid_q.valid <= 1'b1;
            if (ifid_q.valid && jr && (jr_target[1:0] != 2'b00))
                mis_q <= 1'b1;
        end
    end

    assign pc_if       = pc_q;
    assign instr_id    = ifid_q.instr;
    assign pc_id       = ifid_q.pc;
    assign pc8_id      = ifid_q.pc + 32'd8;
    assign id_valid    = ifid_q.valid;
    assign jr_misalign = mis_q;

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection and the IF/ID pipeline register.
- Consumes the word-shifted branch offset produced by the decode-stage immediate extender, plus the jump/jr controls resolved in ID.
- Drives the instruction-memory address and delivers instruction and PC to decode.
- Branches and jumps use one architectural delay slot.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk edge).
- stall  input  1  hazard-unit stall; holds PC and IF/ID.
- instr_if  input  32  instruction word read from IM at pc_if (combinational IM).
- br_taken  input  1  ID-stage branch condition true (beq/bne/... already compared).
- br_offset  input  32  sign-extended offset shifted left 2, from the immediate extender.
- jump  input  1  ID instruction is j/jal.
- j_index  input  26  instr_id[25:0] target index.
- jr  input  1  ID instruction is jr/jalr.
- jr_target  input  32  forwarded rs value.
- pc_if  output  32  current fetch address to IM.
- instr_id  output  32  IF/ID instruction register.
- pc_id  output  32  IF/ID PC register.
- pc8_id  output  32  pc_id + 8, link value for jal/jalr.
- id_valid  output  1  IF/ID holds a fetched instruction (0 after reset until first fetch).
- jr_misalign  output  1  sticky flag: a jr redirect had jr_target[1:0] != 0.

Behaviour:
- Reset (reset==0 at posedge), dominant over every other input:
  - pc_if <= PC_RESET; instr_id <= NOP_WORD; pc_id <= PC_RESET; id_valid <= 0; jr_misalign <= 0.
- pc8_id is combinational: pc_id + 8, 32-bit wrap-around.
- Next-PC selection:
  - Evaluated only when id_valid==1; control inputs are ignored while id_valid==0.
  - Priority: jr > jump > br_taken > sequential.
  - jr: jr_target used unmodified, low bits included.
  - jump: {pc_id_plus4[31:28], j_index, 2'b00}, where pc_id_plus4 = pc_id+4.
  - branch: pc_id + 4 + br_offset, 32-bit modular, overflow discarded.
  - sequential: pc_if + 4, wraps 0xFFFF_FFFC -> 0.
- Normal cycle (reset==1, stall==0):
  - pc_if <= npc; instr_id <= instr_if; pc_id <= pc_if; id_valid <= 1.
  - Delay slot is natural: the instruction fetched in the same cycle the branch sits in ID enters ID next. No flush.
- Stall cycle (stall==1):
  - pc_if, instr_id, pc_id and id_valid hold.
  - Redirect inputs are ignored; the ID instruction re-presents them on the cycle stall drops.
- jr_misalign:
  - Set on a non-stalled cycle where id_valid & jr & (jr_target[1:0]!=0).
  - Cleared only by reset.
- Latency: redirect decided in cycle N appears on pc_if in cycle N+1, with exactly one delay-slot instruction between.
- Simultaneous jump/branch/jr asserted: priority above. The bench treats this as illegal but must see deterministic priority.
- Reset asserted mid-stall or mid-redirect: reset wins, no partial update.

Decomposition:
- Shared package, pipeline constants:
  - PC_RESET value and NOP_WORD.
  - npc select encoding localparams: NPC_SEQ=2'd0, NPC_BR=2'd1, NPC_J=2'd2, NPC_JR=2'd3.
- One natural sub-module: npc_calc, combinational target/priority mux producing npc from pc_if, pc_id, controls and operands.
- fetch_pc keeps only registers, stall gating and the sticky flag.

Test Plan:
- Reset then run 3 cycles, no stall/redirect -> pc_if 0x3000, 0x3004, 0x3008; id_valid 0 then 1; pc_id 0x3000 at cycle 2; pc8_id 0x3008.
- Branch: with pc_id=0x3004, br_taken=1, br_offset=0xFFFF_FFF8 -> delay slot 0x3008 enters ID; next pc_if = 0x3000.
- Jump: with pc_id=0x3010, jump=1, j_index=0x0000C40 -> pc_if becomes 0x0000_3100 after the delay slot; jr with jr_target=0x3202 -> pc_if=0x3202, jr_misalign=1 and stays 1.
- Stall for 2 cycles while branch in ID -> pc_if/instr_id/pc_id unchanged for both cycles; redirect taken on the first unstalled cycle.
- jump=1 and br_taken=1 together -> jump target wins; jr+jump -> jr target wins.
- reset=0 asserted during stall with pending branch -> next cycle pc_if=0x3000, instr_id=0, id_valid=0, jr_misalign=0.
